l0_readout_queue: RTL and testbench
===================================

Name: l0_readout_queue

Overview:
- Sits directly upstream of the local L0ID hold register.
- Accepts L0 accept pulses, assigns each a running L0ID and buffers the tags in a small FIFO.
- Issues one-cycle ROReadStrob requests to the readout path, paced by a busy/done handshake and a minimum strobe spacing.
- Keeps its L0ID counter aligned with the downstream register: same reset/preset semantics, so the first trigger after reset carries 0x00.

Parameters:
- RO_ADDR_WIDTH, 8, L0ID width; taken from the shared `RO_ADDR_WIDTH define.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- MIN_GAP, 4, minimum CLK cycles from one ROReadStrob to the next; range 1..15.

Ports:
- CLK  in  1  bunch-crossing clock.
- ResetB  in  1  asynchronous, active-low reset.
- L0A  in  1  L0 accept pulse, one cycle per trigger.
- L0IDReset  in  1  synchronous L0ID reset and queue flush.
- L0IDPreset  in  1  when 1 during L0IDReset, load PreL0ID instead of 0xFF.
- PreL0ID  in  RO_ADDR_WIDTH  preset value.
- ReadoutBusy  in  1  readout engine cannot accept a request.
- ReadoutDone  in  1  one-cycle pulse: current request finished.
- ROReadStrob  out  1  one-cycle readout request.
- ReqL0ID  out  RO_ADDR_WIDTH  L0ID of the current request; valid while ROReadStrob=1, held afterwards.
- QueueCount  out  $clog2(DEPTH)+1  FIFO occupancy.
- QueueFull  out  1  occupancy == DEPTH.
- Overflow  out  1  sticky: a trigger was dropped.

Behaviour:
- Reset (ResetB=0, asynchronous):
  - L0ID counter = all ones; FIFO empty; FSM in IDLE.
  - ROReadStrob=0, ReqL0ID=0, QueueCount=0, QueueFull=0, Overflow=0.
- L0IDReset=1 (synchronous, highest priority):
  - Counter <= L0IDPreset ? PreL0ID : all ones.
  - FIFO flushed; FSM -> IDLE; Overflow cleared.
  - L0A in the same cycle is ignored.
  - ROReadStrob is forced 0 in the following cycle.
- L0A=1 (no L0IDReset):
  - Counter <= counter+1, modulo 2^RO_ADDR_WIDTH; 0xFF wraps to 0x00.
  - The new value (counter+1) is pushed.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the tag is dropped, Overflow is set, and the counter still increments.
- FSM states: IDLE, STROBE, WAIT_DONE, GAP. All outputs are registered.
  - IDLE: if FIFO not empty and ReadoutBusy=0 -> STROBE.
  - STROBE (1 cycle): ROReadStrob=1, ReqL0ID=head, head popped -> WAIT_DONE.
  - WAIT_DONE: ReadoutDone=1 -> GAP. ReadoutDone in any other state is ignored.
  - GAP: hold until MIN_GAP cycles have elapsed since the strobe cycle -> IDLE. If ReadoutDone arrives late enough that the gap has already elapsed, pass through GAP in one cycle.
- Latency:
  - L0A in cycle n -> tag visible in the FIFO at n+1.
  - Earliest ROReadStrob in cycle n+2 (empty queue, idle readout).
- ReadoutBusy is sampled only in IDLE; it has no effect in the other states.
- QueueCount/QueueFull update in the cycle after a push or pop; simultaneous push and pop leave the count unchanged.

Optional Feature:
- Macro: L0Q_DROP_COUNTER_EN.
- Defined:
  - Adds output DropCount (8 bits), which increments per dropped trigger and saturates at 0xFF.
  - Cleared by reset and by L0IDReset.
- Undefined:
  - Port absent; only the sticky Overflow is reported.

Decomposition:
- Shared package/include holds:
  - RO_ADDR_WIDTH;
  - FSM state encoding (IDLE=2'd0, STROBE=2'd1, WAIT_DONE=2'd2, GAP=2'd3);
  - DEPTH and MIN_GAP defaults.
- One sub-module, l0_tag_fifo:
  - Synchronous FIFO, width RO_ADDR_WIDTH, depth DEPTH, asynchronous active-low reset.
  - Synchronous flush input; count/full/empty outputs.
- The top level contains the counter, push logic, FSM and gap counter.

Test Plan:
- Reset, then L0A at cycle 10, ReadoutBusy=0 -> ROReadStrob at cycle 12 with ReqL0ID=0x00; QueueCount returns to 0.
- L0IDReset with L0IDPreset=1, PreL0ID=0x3C, then 3 L0A pulses -> strobes carry ReqL0ID 0x3D, 0x3E, 0x3F, each ReadoutDone-gated, at least 4 cycles apart.
- 9 back-to-back L0A while ReadoutBusy=1 (DEPTH=8) -> QueueFull=1, Overflow=1, L0IDs 0x00..0x07 read out; the next trigger gets 0x09. With L0Q_DROP_COUNTER_EN, DropCount=1.
- Counter at 0xFE, then 3 triggers -> tags 0xFF, 0x00, 0x01, in order.
- L0IDReset asserted in WAIT_DONE with 3 queued tags -> FIFO empty, FSM IDLE, no further strobe, Overflow=0; a late ReadoutDone is ignored.
- ResetB pulsed low mid-STROBE -> ROReadStrob drops immediately (asynchronously); all outputs take their reset values.

Source files
------------

// File: rtl/l0_readout_queue_pkg.sv
`default_nettype none
// =====================================================================
// l0_readout_queue_pkg : shared L0ID width, defaults and FSM encoding
// Revision: 1.0
// =====================================================================
`ifndef RO_ADDR_WIDTH
`define RO_ADDR_WIDTH 8
`endif

package l0_readout_queue_pkg;

  localparam int RO_ADDR_WIDTH = `RO_ADDR_WIDTH;
  localparam int L0Q_DEPTH     = 8;
  localparam int L0Q_MIN_GAP   = 4;
  localparam int GAP_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STROBE    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } l0q_state_e;

  function automatic logic [GAP_CNT_W-1:0] gap_inc(input logic [GAP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/l0_tag_fifo.sv
`default_nettype none
// =====================================================================
// l0_tag_fifo : synchronous tag FIFO with flush, count/full/empty
// Revision: 1.0
// =====================================================================
module l0_tag_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/l0_readout_queue.sv
`default_nettype none
// =====================================================================
// l0_readout_queue : L0ID tagging, trigger queue and paced ROReadStrob
// Optional build macro L0Q_DROP_COUNTER_EN adds the DropCount output.
// Revision: 1.0
// =====================================================================
module l0_readout_queue
  import l0_readout_queue_pkg::*;
#(
  parameter  int DEPTH   = L0Q_DEPTH,
  parameter  int MIN_GAP = L0Q_MIN_GAP,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                     CLK,
  input  logic                     ResetB,
  input  logic                     L0A,
  input  logic                     L0IDReset,
  input  logic                     L0IDPreset,
  input  logic [RO_ADDR_WIDTH-1:0] PreL0ID,
  input  logic                     ReadoutBusy,
  input  logic                     ReadoutDone,
  output logic                     ROReadStrob,
  output logic [RO_ADDR_WIDTH-1:0] ReqL0ID,
  output logic [CW-1:0]            QueueCount,
  output logic                     QueueFull,
  output logic                     Overflow
`ifdef L0Q_DROP_COUNTER_EN
  ,
  output logic [7:0]               DropCount
`endif
);

  l0q_state_e               state_q, state_d;
  logic [RO_ADDR_WIDTH-1:0] l0id_q, l0id_d;
  logic [RO_ADDR_WIDTH-1:0] req_id_q, req_id_d;
  logic [GAP_CNT_W-1:0]     gap_q, gap_d;
  logic                     strobe_q, strobe_d;
  logic                     ovf_q, ovf_d;

  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [RO_ADDR_WIDTH-1:0] fifo_head, next_id;
  logic                     drop, gap_elapsed;

  assign next_id   = l0id_q + 1'b1;
  assign fifo_push = L0A && !L0IDReset;
  assign fifo_pop  = (state_q == ST_STROBE);
  assign drop      = fifo_push && fifo_full && !fifo_pop;

  // gap_q counts cycles since the last strobe; IDLE->STROBE adds one more
  // cycle, so leaving GAP two short of MIN_GAP lands the next strobe on time.
  assign gap_elapsed = (int'(gap_q) + 2) >= MIN_GAP;

  l0_tag_fifo #(
    .WIDTH (RO_ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (ResetB),
    .flush     (L0IDReset),
    .push      (fifo_push),
    .push_data (next_id),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (QueueCount),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    l0id_d = l0id_q;
    ovf_d  = ovf_q;
    if (L0IDReset) begin
      l0id_d = L0IDPreset ? PreL0ID : '1;
      ovf_d  = 1'b0;
    end else if (L0A) begin
      l0id_d = next_id;
      if (drop) ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!fifo_empty && !ReadoutBusy) state_d = ST_STROBE;
      ST_STROBE:    state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (ReadoutDone) state_d = ST_GAP;
      ST_GAP:       if (gap_elapsed) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (L0IDReset) state_d = ST_IDLE;

    strobe_d = (state_d == ST_STROBE);
    req_id_d = strobe_d ? fifo_head : req_id_q;
    gap_d    = strobe_d ? '0 : gap_inc(gap_q);
  end

  always_ff @(posedge CLK or negedge ResetB) begin
    if (!ResetB) begin
      state_q  <= ST_IDLE;
      l0id_q   <= '1;
      req_id_q <= '0;
      gap_q    <= '0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      l0id_q   <= l0id_d;
      req_id_q <= req_id_d;
      gap_q    <= gap_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ROReadStrob = strobe_q;
  assign ReqL0ID     = req_id_q;
  assign QueueFull   = fifo_full;
  assign Overflow    = ovf_q;

`ifdef L0Q_DROP_COUNTER_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (L0IDReset) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge ResetB) begin
    if (!ResetB) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign DropCount = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l0_readout_queue.sv
`default_nettype none
// =====================================================================
// tb_l0_readout_queue : directed self-checking bench for l0_readout_queue
// Revision: 1.0
// =====================================================================
module tb_l0_readout_queue;
  import l0_readout_queue_pkg::*;

  logic                     CLK = 1'b0;
  logic                     ResetB = 1'b0;
  logic                     L0A = 1'b0;
  logic                     L0IDReset = 1'b0;
  logic                     L0IDPreset = 1'b0;
  logic [RO_ADDR_WIDTH-1:0] PreL0ID = '0;
  logic                     ReadoutBusy = 1'b0;
  logic                     ReadoutDone = 1'b0;
  logic                     ROReadStrob;
  logic [RO_ADDR_WIDTH-1:0] ReqL0ID;
  logic [$clog2(L0Q_DEPTH):0] QueueCount;
  logic                     QueueFull;
  logic                     Overflow;
`ifdef L0Q_DROP_COUNTER_EN
  logic [7:0]               DropCount;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;

  l0_readout_queue dut (
    .CLK         (CLK),
    .ResetB      (ResetB),
    .L0A         (L0A),
    .L0IDReset   (L0IDReset),
    .L0IDPreset  (L0IDPreset),
    .PreL0ID     (PreL0ID),
    .ReadoutBusy (ReadoutBusy),
    .ReadoutDone (ReadoutDone),
    .ROReadStrob (ROReadStrob),
    .ReqL0ID     (ReqL0ID),
    .QueueCount  (QueueCount),
    .QueueFull   (QueueFull),
    .Overflow    (Overflow)
`ifdef L0Q_DROP_COUNTER_EN
    ,
    .DropCount   (DropCount)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input int bound, output int at);
    int n = 0;
    while (ROReadStrob !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    checks++;
    assert (ROReadStrob === 1'b1) else begin
      failures++;
      $error("FAIL strobe_timeout observed=%b expected=1 after %0d cycles", ROReadStrob, n);
    end
    at = cyc;
  endtask

  // Called in the strobe cycle; answers with ReadoutDone after 'delay' extra cycles.
  task automatic done_hs(input int delay);
    tick();
    repeat (delay) tick();
    ReadoutDone = 1'b1;
    tick();
    ReadoutDone = 1'b0;
  endtask

  task automatic trig(input int n);
    L0A = 1'b1;
    repeat (n) tick();
    L0A = 1'b0;
  endtask

  initial begin
    int at, prev, seen;
    logic [7:0] exp_id;

    // Reset values
    repeat (3) tick();
    chk("rst_strobe", 32'(ROReadStrob), 0);
    chk("rst_reqid", 32'(ReqL0ID), 0);
    chk("rst_count", 32'(QueueCount), 0);
    chk("rst_full", 32'(QueueFull), 0);
    chk("rst_ovf", 32'(Overflow), 0);
`ifdef L0Q_DROP_COUNTER_EN
    chk("rst_dropcnt", 32'(DropCount), 0);
`endif
    ResetB = 1'b1;
    repeat (6) tick();

    // First trigger after reset: tag 0x00, strobe two cycles after L0A
    trig(1);
    chk("t1_count1", 32'(QueueCount), 1);
    chk("t1_nostrobe", 32'(ROReadStrob), 0);
    tick();
    chk("t1_strobe", 32'(ROReadStrob), 1);
    chk("t1_id", 32'(ReqL0ID), 32'h00);
    done_hs(0);
    chk("t1_count0", 32'(QueueCount), 0);
    chk("t1_idhold", 32'(ReqL0ID), 32'h00);

    // Preset 0x3C, three tags, strobe spacing controlled by done/gap
    L0IDReset = 1'b1; L0IDPreset = 1'b1; PreL0ID = 8'h3C; ReadoutBusy = 1'b1;
    tick();
    L0IDReset = 1'b0; L0IDPreset = 1'b0;
    trig(3);
    chk("t2_count3", 32'(QueueCount), 3);
    ReadoutBusy = 1'b0;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(20, at);
      exp_id = 8'h3D + 8'(k);
      chk("t2_id", 32'(ReqL0ID), 32'(exp_id));
      if (k == 1) chk("t2_space_min", at - prev, 4);
      if (k == 2) chk("t2_space_late", at - prev, 8);
      prev = at;
      done_hs((k == 1) ? 4 : 0);
    end
    chk("t2_empty", 32'(QueueCount), 0);

    // Fill with readout busy: 8 queued, 9th dropped
    L0IDReset = 1'b1; ReadoutBusy = 1'b1;
    tick();
    L0IDReset = 1'b0;
    trig(9);
    chk("t3_count8", 32'(QueueCount), 8);
    chk("t3_full", 32'(QueueFull), 1);
    chk("t3_ovf", 32'(Overflow), 1);
`ifdef L0Q_DROP_COUNTER_EN
    chk("t3_dropcnt", 32'(DropCount), 1);
`endif
    repeat (2) tick();
    chk("t3_busy_nostrobe", 32'(ROReadStrob), 0);
    ReadoutBusy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_strobe(20, at);
      chk("t3_id", 32'(ReqL0ID), i);
      done_hs(0);
    end
    chk("t3_drained", 32'(QueueCount), 0);
    chk("t3_ovf_sticky", 32'(Overflow), 1);
    trig(1);
    wait_strobe(10, at);
    chk("t3_next_id", 32'(ReqL0ID), 32'h09);
    done_hs(0);

    // L0IDReset while waiting for done with three tags queued
    trig(4);
    chk("t5_count3", 32'(QueueCount), 3);
    chk("t5_wait_nostrobe", 32'(ROReadStrob), 0);
    L0IDReset = 1'b1; L0A = 1'b1;
    tick();
    L0IDReset = 1'b0; L0A = 1'b0;
    chk("t5_flushed", 32'(QueueCount), 0);
    chk("t5_strobe0", 32'(ROReadStrob), 0);
    chk("t5_ovf_clr", 32'(Overflow), 0);
`ifdef L0Q_DROP_COUNTER_EN
    chk("t5_dropcnt_clr", 32'(DropCount), 0);
`endif
    ReadoutDone = 1'b1;
    tick();
    ReadoutDone = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (ROReadStrob === 1'b1) seen++;
    end
    chk("t5_no_strobe", seen, 0);
    trig(1);
    tick();
    chk("t5_idle_strobe", 32'(ROReadStrob), 1);
    chk("t5_id", 32'(ReqL0ID), 32'h00);
    done_hs(0);

    // Counter wrap through 0xFF
    L0IDReset = 1'b1; L0IDPreset = 1'b1; PreL0ID = 8'hFE; ReadoutBusy = 1'b1;
    tick();
    L0IDReset = 1'b0; L0IDPreset = 1'b0;
    trig(3);
    ReadoutBusy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(20, at);
      exp_id = 8'hFF + 8'(k);
      chk("t4_wrap_id", 32'(ReqL0ID), 32'(exp_id));
      done_hs(0);
    end

    // Asynchronous reset in the middle of a strobe cycle
    trig(1);
    tick();
    chk("t6_strobe", 32'(ROReadStrob), 1);
    chk("t6_id", 32'(ReqL0ID), 32'h02);
    #3 ResetB = 1'b0;
    #1;
    chk("t6_async_strobe", 32'(ROReadStrob), 0);
    chk("t6_async_reqid", 32'(ReqL0ID), 0);
    chk("t6_async_count", 32'(QueueCount), 0);
    chk("t6_async_ovf", 32'(Overflow), 0);
    tick();
    ResetB = 1'b1;
    tick();
    trig(1);
    tick();
    chk("t6_post_strobe", 32'(ROReadStrob), 1);
    chk("t6_post_id", 32'(ReqL0ID), 32'h00);
    done_hs(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
